// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract controller: FSM states and opcodes.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add1.sv
// 1-bit full adder cell used as the serial datapath; purely combinational.
module add1 (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first, done WIDTH+1 cycles after start.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    count;
    logic             carry;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;

    add1 u_add1 (
        .sum  (sum_bit),
        .cout (carry_nxt),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry)
    );

    assign last_bit = (count == CW'(WIDTH - 1));
    // The running carry doubles as cout; it is frozen outside RUN so it holds after done.
    assign cout     = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            count  <= '0;
            carry  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
                        a_sh   <= a;
                        b_sh   <= (op == OP_SUB) ? ~b : b;
                        carry  <= (op == OP_SUB);
                        count  <= '0;
                        result <= '0;
                        state  <= RUN;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    result <= {sum_bit, result[WIDTH-1:1]};
                    carry  <= carry_nxt;
                    count  <= count + CW'(1);
                    if (last_bit) begin
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ carry_nxt;
`endif
                        state <= DONE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with an arithmetic reference model checked every cycle.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           due;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference arithmetic: modular result, carry/no-borrow, two's-complement overflow.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input int due);
        exp_t e;
        int   ix, iy, full;
        ix = int'(x);
        iy = int'(y);
        e.due = due;
        if (o) begin
            full = ix - iy;
            e.co = (ix >= iy);
        end else begin
            full = ix + iy;
            e.co = (full >= (1 << W));
        end
        e.res = W'(full);
        if (o) e.ov = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        else   e.ov = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        return e;
    endfunction

    // Compare process: owns the model; checks the current cycle, then predicts the next edge.
    always @(negedge clk) begin : cmp
        exp_t         q[$];
        logic         live;
        logic         hold_vld;
        logic [W-1:0] hold_res;
        logic         hold_co;
        logic         hold_ov;
        logic         ed, eb;
        if (live === 1'b1) begin
            ed = (q.size() > 0) && (q[0].due == cyc);
            eb = (q.size() > 0) && (q[0].due > cyc);
            chk("done", done, ed);
            chk("busy", busy, eb);
            chk("ready", ready, !eb);
            if (ed) begin
                chk("result", result, q[0].res);
                chk("cout", cout, q[0].co);
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", ovf, q[0].ov);
`endif
                hold_vld = 1'b1;
                hold_res = q[0].res;
                hold_co  = q[0].co;
                hold_ov  = q[0].ov;
                void'(q.pop_front());
            end else if (q.size() == 0 && hold_vld) begin
                chk("hold_result", result, hold_res);
                chk("hold_cout", cout, hold_co);
`ifdef SERIAL_ADD_OVF_EN
                chk("hold_ovf", ovf, hold_ov);
`endif
            end
        end else begin
            eb = 1'b0;
        end
        if (rst === 1'b1) begin
            q.delete();
            live     = 1'b1;
            hold_vld = 1'b1;
            hold_res = '0;
            hold_co  = 1'b0;
            hold_ov  = 1'b0;
        end else if (live === 1'b1 && start === 1'b1 && !eb) begin
            q.push_back(model(op, a, b, cyc + 1 + W));
            hold_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Latency counts the cycle after the sampling edge as cycle 1; done should land on cycle W+1.
    task automatic wait_done(input int already, output int lat);
        int n;
        n = already;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
        lat = n + 1;
    endtask

    task automatic lit_op(input string nm, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        issue(o, x, y);
        wait_done(0, lat);
        chk({nm, "_lat"}, lat, 9);
        chk({nm, "_res"}, result, er);
        chk({nm, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) chk({nm, "_ovf"}, 32'd0, 32'd1);
`endif
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : drive
        int lat, pulses, t1, t2, t3;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_cout", cout, 1'b0);
        tick(); tick();

        lit_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        lit_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        lit_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        lit_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        lit_op("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
        lit_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        lit_op("sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();

        // Start and new operands at RUN cycle 4 must be ignored.
        issue(1'b0, 8'h3C, 8'h21);
        repeat (3) tick();
        start = 1'b1; op = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        wait_done(4, lat);
        chk("busy_start_lat", lat, 9);
        chk("busy_start_res", result, 8'h5D);
        pulses = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("busy_start_extra_done", pulses, 0);

        // Reset during RUN cycle 5 aborts with no done pulse.
        issue(1'b0, 8'h12, 8'h34);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 8'h00);
        pulses = 0;
        repeat (12) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        chk("abort_no_done", pulses, 0);
        lit_op("after_abort", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        // Start held across DONE: three operations back to back.
        op = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
        tick();
        op = 1'b1; a = 8'h40; b = 8'h41;
        wait_done(0, lat);
        chk("b2b0_lat", lat, 9);
        chk("b2b0_res", result, 8'h33);
        t1 = cyc;
        tick();
        op = 1'b0; a = 8'hC8; b = 8'h64;
        wait_done(0, lat);
        chk("b2b1_res", result, 8'hFF);
        chk("b2b1_cout", cout, 1'b0);
        t2 = cyc;
        chk("b2b_gap1", t2 - t1, 9);
        tick();
        start = 1'b0;
        wait_done(0, lat);
        chk("b2b2_res", result, 8'h2C);
        chk("b2b2_cout", cout, 1'b1);
        t3 = cyc;
        chk("b2b_gap2", t3 - t2, 9);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request an operation; sampled only while ready=1.
REQ-005 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL have port a  input  WIDTH  first operand, captured on accepted start.
REQ-007 SHALL have port b  input  WIDTH  second operand, captured on accepted start.
REQ-008 SHALL have port ready  output  1  high in IDLE and DONE; controller can accept start.
REQ-009 SHALL have port busy  output  1  high in RUN only.
REQ-010 SHALL have port done  output  1  single-cycle pulse; result and flags valid.
REQ-011 SHALL have port result  output  WIDTH  sum/difference; held until next accepted start.
REQ-012 SHALL have port cout  output  1  final carry out; for subtract, 1 = no borrow.

Function
REQ-013 SHALL sequence one 1-bit full-adder cell over the operands LSB first, one bit per clock.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> capture a, b (b bit-inverted when op=1), carry <= op, bit count <= 0, result <= 0; go to RUN.
REQ-016 RUN: each cycle, add the current operand bits and the carry, shift the sum bit into result MSB (right shift), register carry-out, increment count; after bit WIDTH-1 go to DONE.
REQ-017 DONE: done=1 for exactly this cycle; cout = final carry; return to IDLE, or to RUN if start=1 (back-to-back accepted).
REQ-018 Latency SHALL be exactly WIDTH+1 cycles from the start-sampling edge to the done cycle (WIDTH=8 gives 9).
REQ-019 start while busy=1 SHALL be ignored with no effect on the operation or outputs.
REQ-020 Operands SHALL be read only at the capture edge; a/b/op changes during RUN SHALL NOT affect the result.
REQ-021 result and cout SHALL stay stable from done until the next accepted start; during RUN they are invalid.
REQ-022 Results SHALL wrap modulo 2^WIDTH; overflow beyond WIDTH is reported only by cout (and ovf, REQ-027).

Reset
REQ-023 rst=1 SHALL force IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, count=0, carry=0.
REQ-024 rst during RUN SHALL abort the operation with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-025 Macro SERIAL_ADD_OVF_EN SHALL control the signed-overflow flag.
REQ-026 Without the macro, port ovf and its logic SHALL be absent.
REQ-027 With the macro, port ovf (output, 1) SHALL equal carry into bit WIDTH-1 XOR final carry out, valid with done and held like result.

Structure
REQ-028 A shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the opcode constants OP_ADD=0, OP_SUB=1.
REQ-029 SHALL instantiate exactly one sub-module: the team's 1-bit full adder add1 (ports sum, cout, a, b, cin) as the datapath cell.
REQ-030 Bit counter width SHALL be $clog2(WIDTH)+1; all other state is local registers.

Verification
REQ-031 add 8'h0F + 8'h01 -> done after 9 cycles, result=8'h10, cout=0, ovf=0.
REQ-032 add 8'hFF + 8'h01 -> result=8'h00, cout=1, ovf=0; add 8'h7F + 8'h01 -> result=8'h80, cout=0, ovf=1.
REQ-033 sub 8'h05 - 8'h07 -> result=8'hFE, cout=0 (borrow); sub 8'h07 - 8'h05 -> result=8'h02, cout=1.
REQ-034 start pulsed and a/b changed at cycle 4 of RUN -> ignored, original result delivered, single done pulse.
REQ-035 rst asserted at cycle 5 of RUN -> next cycle ready=1, busy=0, result=0, no done pulse; a new start then completes normally.
REQ-036 start held high across DONE -> back-to-back operations, done pulses exactly 9 cycles apart, each result correct.
